// File: rtl/sauria_pkg.sv
// Shared types for the SAURIA config-bus sequencer.
// Opcodes, error codes, FSM states, AXI resp.
package sauria_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_POLL     = 2'd1,
    OP_WAIT_IRQ = 2'd2,
    OP_END      = 2'd3
  } seq_op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RESP    = 2'd1,
    ERR_POLL_TO = 2'd2,
    ERR_PC_OVR  = 2'd3
  } seq_err_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_WAIT_IRQ,
    S_DONE,
    S_ERROR
  } seq_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

endpackage

// File: rtl/sauria_seq_prog_mem.sv
// Program table: one write port, one registered read.
// Contents are intentionally not reset.
module sauria_seq_prog_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 66,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // table write and synchronous read
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    if (re) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/sauria_cfg_sequencer.sv
// Runs a small register program over AXI4-Lite:
// writes, polls, irq waits, end.
module sauria_cfg_sequencer
  import sauria_pkg::*;
#(
  parameter int CFG_AXI_ADDR_WIDTH = 32,
  parameter int CFG_AXI_DATA_WIDTH = 32,
  parameter int PROG_DEPTH         = 64,
  parameter int POLL_MAX_READS     = 1024,
  localparam int PW = $clog2(PROG_DEPTH),
  localparam int AW = CFG_AXI_ADDR_WIDTH,
  localparam int DW = CFG_AXI_DATA_WIDTH
) (
  input  logic          i_system_clk,
  input  logic          i_system_rstn,
  input  logic          i_prog_we,
  input  logic [PW-1:0] i_prog_idx,
  input  logic [1:0]    i_prog_op,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [DW-1:0] i_prog_data,
  input  logic          i_start,
  input  logic          i_irq,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [1:0]    o_err_code,
  output logic [PW-1:0] o_pc,
  output logic [AW-1:0] o_cfg_axi_awaddr,
  output logic          o_cfg_axi_awvalid,
  input  logic          i_cfg_axi_awready,
  output logic [DW-1:0] o_cfg_axi_wdata,
  output logic [DW/8-1:0] o_cfg_axi_wstrb,
  output logic          o_cfg_axi_wvalid,
  input  logic          i_cfg_axi_wready,
  input  logic [1:0]    i_cfg_axi_bresp,
  input  logic          i_cfg_axi_bvalid,
  output logic          o_cfg_axi_bready,
  output logic [AW-1:0] o_cfg_axi_araddr,
  output logic          o_cfg_axi_arvalid,
  input  logic          i_cfg_axi_arready,
  input  logic [DW-1:0] i_cfg_axi_rdata,
  input  logic [1:0]    i_cfg_axi_rresp,
  input  logic          i_cfg_axi_rvalid,
  output logic          o_cfg_axi_rready
);

  localparam int EW = 2 + AW + DW;
  localparam int CW = $clog2(POLL_MAX_READS + 1);
  localparam logic [PW-1:0] PC_LAST = PW'(PROG_DEPTH - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX_READS - 1);

  seq_state_e    state_q, state_d;
  seq_err_e      err_q, err_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] poll_q, poll_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          done_q, done_d;
  logic          adv;
  logic          idle_like;
  logic          aw_hs, w_hs;

  logic [EW-1:0] ent;
  seq_op_e       ent_op;
  logic [AW-1:0] ent_addr;
  logic [DW-1:0] ent_data;

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE) ||
                     (state_q == S_ERROR);

  assign ent_op   = seq_op_e'(ent[EW-1 -: 2]);
  assign ent_addr = ent[DW +: AW];
  assign ent_data = ent[DW-1:0];

  assign aw_hs = o_cfg_axi_awvalid && i_cfg_axi_awready;
  assign w_hs  = o_cfg_axi_wvalid && i_cfg_axi_wready;

  // the entry is read on the edge into FETCH,
  // so FETCH itself can decode it
  sauria_seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .W     (EW)
  ) u_prog_mem (
    .clk     (i_system_clk),
    .we      (i_prog_we && idle_like),
    .wr_idx  (i_prog_idx),
    .wr_data ({i_prog_op, i_prog_addr, i_prog_data}),
    .re      (state_d == S_FETCH),
    .rd_idx  (pc_d),
    .rd_data (ent)
  );

  // state register
  always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
    if (!i_system_rstn) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_NONE;
      pc_q      <= '0;
      poll_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      pc_q      <= pc_d;
      poll_q    <= poll_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
    end
  end

  // next-state and sequencing decisions
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    pc_d      = pc_q;
    poll_d    = poll_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    adv       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          err_d   = ERR_NONE;
        end
      end
      S_FETCH: begin
        poll_d    = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        unique case (ent_op)
          OP_WRITE:    state_d = S_WR_REQ;
          OP_POLL:     state_d = S_RD_REQ;
          OP_WAIT_IRQ: state_d = S_WAIT_IRQ;
          default:     state_d = S_DONE;
        endcase
      end
      S_WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_cfg_axi_bvalid) begin
          if (i_cfg_axi_bresp != AXI_RESP_OKAY) begin
            state_d = S_ERROR;
            err_d   = ERR_RESP;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (i_cfg_axi_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (i_cfg_axi_rvalid) begin
          if (i_cfg_axi_rresp != AXI_RESP_OKAY) begin
            state_d = S_ERROR;
            err_d   = ERR_RESP;
          end else if (|(i_cfg_axi_rdata & ent_data)) begin
            adv = 1'b1;
          end else if (poll_q == POLL_LAST) begin
            state_d = S_ERROR;
            err_d   = ERR_POLL_TO;
          end else begin
            poll_d  = poll_q + CW'(1);
            state_d = S_RD_REQ;
          end
        end
      end
      S_WAIT_IRQ: begin
        if (i_irq) adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (pc_q == PC_LAST) begin
        state_d = S_ERROR;
        err_d   = ERR_PC_OVR;
      end else begin
        pc_d    = pc_q + PW'(1);
        state_d = S_FETCH;
      end
    end
  end

  assign done_d = (state_q == S_FETCH) && (state_d == S_DONE);

  // AXI and status outputs
  always_comb begin
    o_cfg_axi_awaddr  = ent_addr;
    o_cfg_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
    o_cfg_axi_wdata   = ent_data;
    o_cfg_axi_wstrb   = '1;
    o_cfg_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
    o_cfg_axi_bready  = (state_q == S_WR_RESP);
    o_cfg_axi_araddr  = ent_addr;
    o_cfg_axi_arvalid = (state_q == S_RD_REQ);
    o_cfg_axi_rready  = (state_q == S_RD_RESP);
    o_busy            = !idle_like;
    o_done            = done_q;
    o_error           = (state_q == S_ERROR);
    o_err_code        = err_q;
    o_pc              = pc_q;
  end

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Directed bench for sauria_cfg_sequencer with a
// small procedural AXI4-Lite slave.
module tb_sauria_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        prog_we;
  logic [2:0]  prog_idx;
  logic [1:0]  prog_op;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        irq;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [2:0]  pc;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int checks = 0;
  int errs   = 0;

  // slave config and observations
  int aw_delay, irq_at, we_at;
  logic [1:0] bresp_cfg;
  logic [31:0] rq[$];
  int r_idx, aw_cnt;
  int n_aw, n_w, n_b, n_ar, n_r;
  int first_aw, aw_stall, w_hi, stab_err, done_seen;
  logic [31:0] aw_addr_s, wdata_s, araddr_s;
  logic [3:0]  wstrb_s;
  bit aw_got, w_got, r_pend;
  bit p_aw, p_w, p_b, p_ar, p_r;
  bit pv_aw, pv_w, pv_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  sauria_cfg_sequencer #(
    .CFG_AXI_ADDR_WIDTH (32),
    .CFG_AXI_DATA_WIDTH (32),
    .PROG_DEPTH         (8),
    .POLL_MAX_READS     (4)
  ) dut (
    .i_system_clk      (clk),
    .i_system_rstn     (rstn),
    .i_prog_we         (prog_we),
    .i_prog_idx        (prog_idx),
    .i_prog_op         (prog_op),
    .i_prog_addr       (prog_addr),
    .i_prog_data       (prog_data),
    .i_start           (start),
    .i_irq             (irq),
    .o_busy            (busy),
    .o_done            (done),
    .o_error           (error),
    .o_err_code        (err_code),
    .o_pc              (pc),
    .o_cfg_axi_awaddr  (awaddr),
    .o_cfg_axi_awvalid (awvalid),
    .i_cfg_axi_awready (awready),
    .o_cfg_axi_wdata   (wdata),
    .o_cfg_axi_wstrb   (wstrb),
    .o_cfg_axi_wvalid  (wvalid),
    .i_cfg_axi_wready  (wready),
    .i_cfg_axi_bresp   (bresp),
    .i_cfg_axi_bvalid  (bvalid),
    .o_cfg_axi_bready  (bready),
    .o_cfg_axi_araddr  (araddr),
    .o_cfg_axi_arvalid (arvalid),
    .i_cfg_axi_arready (arready),
    .i_cfg_axi_rdata   (rdata),
    .i_cfg_axi_rresp   (rresp),
    .i_cfg_axi_rvalid  (rvalid),
    .o_cfg_axi_rready  (rready)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {awvalid, wvalid, bready, arvalid, rready,
            busy, done, error, err_code, pc};
  endfunction

  task automatic slave_clr();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    pv_aw = 0; pv_w = 0; pv_ar = 0;
  endtask

  task automatic clr_stats();
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    first_aw = -1; aw_stall = 0; w_hi = 0;
    stab_err = 0; done_seen = 0; r_idx = 0;
    rq.delete();
    aw_addr_s = 0; wdata_s = 0; araddr_s = 0; wstrb_s = 0;
  endtask

  task automatic prog(input int idx, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_we = 1; prog_idx = 3'(idx); prog_op = op;
    prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // one negedge per cycle: account handshakes, drive slave
  task automatic serve(input int max_cyc, input bit need_idle);
    int cyc = 0;
    bit fin = 0;
    while (!fin && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (pv_aw && !p_aw && (!awvalid || awaddr != p_awaddr)) stab_err++;
      if (pv_w && !p_w && (!wvalid || wdata != p_wdata)) stab_err++;
      if (pv_ar && !p_ar && (!arvalid || araddr != p_araddr)) stab_err++;
      if (p_aw) begin n_aw++; aw_got = 1; aw_addr_s = p_awaddr; end
      if (p_w) begin
        n_w++; w_got = 1; wdata_s = p_wdata; wstrb_s = p_wstrb;
      end
      if (p_b) begin n_b++; bvalid = 0; end
      if (p_ar) begin n_ar++; r_pend = 1; araddr_s = p_araddr; end
      if (p_r) begin n_r++; rvalid = 0; end
      if (awvalid && first_aw < 0) first_aw = cyc;
      if (wvalid) w_hi++;
      done_seen += int'(done);
      if (awvalid) aw_cnt++;
      else aw_cnt = 0;
      awready = awvalid && (aw_cnt > aw_delay);
      if (awvalid && !awready) aw_stall++;
      wready = wvalid;
      if (aw_got && w_got && !bvalid) begin
        bvalid = 1; bresp = bresp_cfg; aw_got = 0; w_got = 0;
      end
      arready = arvalid;
      if (r_pend && !rvalid) begin
        rvalid = 1; rresp = 0;
        rdata = (r_idx < rq.size()) ? rq[r_idx] : 32'h0;
        r_idx++; r_pend = 0;
      end
      if (irq_at >= 0) irq = (cyc >= irq_at);
      prog_we = (cyc == we_at);
      if (prog_we) begin
        prog_idx = 3'd1; prog_op = 2'd3; prog_addr = 0; prog_data = 0;
      end
      pv_aw = awvalid; p_aw = awvalid && awready;
      p_awaddr = awaddr;
      pv_w = wvalid; p_w = wvalid && wready;
      p_wdata = wdata; p_wstrb = wstrb;
      pv_ar = arvalid; p_ar = arvalid && arready;
      p_araddr = araddr;
      p_b = bvalid && bready;
      p_r = rvalid && rready;
      if (need_idle && !busy) fin = 1;
    end
    if (need_idle && !fin) chk("serve_timeout", busy, 0);
  endtask

  initial begin
    rstn = 0; start = 0; irq = 0;
    prog_we = 0; prog_idx = 0; prog_op = 0;
    prog_addr = 0; prog_data = 0;
    aw_delay = 0; irq_at = -1; we_at = -1; bresp_cfg = 0;
    slave_clr();
    clr_stats();
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rstn = 1;

    // basic write then END
    prog(0, 2'd0, 32'h10, 32'hA5);
    prog(1, 2'd3, 0, 0);
    do_start();
    chk("t1_fetch", {busy, awvalid}, 2'b10);
    serve(40, 1);
    chk("t1_aw_latency", first_aw, 1);
    chk("t1_n_aw", n_aw, 1);
    chk("t1_awaddr", aw_addr_s, 32'h10);
    chk("t1_wdata", wdata_s, 32'hA5);
    chk("t1_wstrb", wstrb_s, 4'hF);
    chk("t1_n_b", n_b, 1);
    chk("t1_done", done_seen, 1);
    chk("t1_err", {error, err_code}, 0);
    @(negedge clk);
    chk("t1_done_1cyc", done, 0);

    // awready held off three cycles
    clr_stats(); slave_clr();
    aw_delay = 3;
    do_start();
    serve(40, 1);
    chk("t2_aw_stall", aw_stall, 3);
    chk("t2_w_hi", w_hi, 1);
    chk("t2_n_aw_w", {n_aw[7:0], n_w[7:0]}, 16'h0101);
    chk("t2_n_b", n_b, 1);
    chk("t2_stable", stab_err, 0);
    chk("t2_done", done_seen, 1);
    aw_delay = 0;

    // poll succeeds on third read
    clr_stats(); slave_clr();
    prog(0, 2'd1, 32'h08, 32'h1);
    rq = '{32'h0, 32'h0, 32'h1};
    do_start();
    serve(60, 1);
    chk("t3_n_ar", n_ar, 3);
    chk("t3_n_r", n_r, 3);
    chk("t3_araddr", araddr_s, 32'h08);
    chk("t3_done", done_seen, 1);
    chk("t3_err", error, 0);
    chk("t3_stable", stab_err, 0);

    // poll timeout after four reads
    clr_stats(); slave_clr();
    do_start();
    serve(60, 1);
    chk("t4_n_ar", n_ar, 4);
    chk("t4_err", {error, err_code}, 3'b110);
    chk("t4_done", done_seen, 0);
    begin
      int quiet = 0;
      repeat (5) begin
        @(negedge clk);
        quiet += int'(awvalid | wvalid | arvalid | bready | rready);
      end
      chk("t4_error_quiet", quiet, 0);
      chk("t4_error_held", error, 1);
    end

    // SLVERR on write, then clean rerun
    clr_stats(); slave_clr();
    prog(0, 2'd0, 32'h30, 32'h77);
    bresp_cfg = 2'd2;
    do_start();
    serve(40, 1);
    chk("t5_n_b", n_b, 1);
    chk("t5_err", {error, err_code}, 3'b101);
    clr_stats(); slave_clr();
    bresp_cfg = 2'd0;
    do_start();
    chk("t5_err_clr", {error, err_code}, 0);
    serve(40, 1);
    chk("t5_rerun_aw", aw_addr_s, 32'h30);
    chk("t5_rerun_done", done_seen, 1);
    chk("t5_rerun_err", error, 0);

    // irq wait, ignored prog write, reset mid-write
    clr_stats(); slave_clr();
    prog(0, 2'd2, 0, 0);
    prog(1, 2'd0, 32'h20, 32'h55);
    prog(2, 2'd3, 0, 0);
    irq = 0; irq_at = 10; we_at = 3; aw_delay = 50;
    do_start();
    serve(16, 0);
    chk("t6_aw_after_irq", first_aw, 12);
    chk("t6_pc", pc, 1);
    chk("t6_aw_held", awvalid, 1);
    chk("t6_awaddr", awaddr, 32'h20);
    rstn = 0;
    #1;
    chk("t6_reset_outputs", outs(), 0);
    irq = 0; irq_at = -1; we_at = -1; prog_we = 0;
    slave_clr();
    @(negedge clk);
    rstn = 1;

    // table survives reset; irq already high
    clr_stats(); aw_delay = 0;
    irq = 1;
    do_start();
    serve(40, 1);
    chk("t7_aw_latency", first_aw, 3);
    chk("t7_awaddr", aw_addr_s, 32'h20);
    chk("t7_wdata", wdata_s, 32'h55);
    chk("t7_done", done_seen, 1);

    // program with no END overruns pc
    for (int i = 0; i < 8; i++) prog(i, 2'd2, 0, 0);
    clr_stats(); slave_clr();
    do_start();
    serve(60, 1);
    chk("t8_err", {error, err_code}, 3'b111);
    chk("t8_pc", pc, 7);
    chk("t8_done", done_seen, 0);
    irq = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errs);
    $finish;
  end

endmodule
